reg_file_arb: RTL and testbench
===============================

REG_FILE_ARB -- requirements
Module: reg_file_arb

Interface
REQ-001 Parameter INIT_CLEAR, default 1: when 1, the block SHALL clear the register file once after reset; when 0, it SHALL skip the clear.
REQ-002 clk  in  1  single clock; all state SHALL change on posedge clk.
REQ-003 nClear  in  1  reset, asynchronous, active-low.
REQ-004 req0_valid, req1_valid  in  1 each  requester command valid.
REQ-005 req0_ready, req1_ready  out  1 each  command accepted this cycle; accept SHALL mean valid && ready.
REQ-006 req0_we, req1_we  in  1 each  1 = write, 0 = read.
REQ-007 req0_aaddr, req0_baddr, req0_caddr, req1_* (same three)  in  4 each  read ports A/B address and write address.
REQ-008 req0_data, req1_data  in  16 each  write data.
REQ-009 rsp0_valid, rsp1_valid  out  1 each  read response valid.
REQ-010 rsp0_a, rsp0_b, rsp1_a, rsp1_b  out  16 each  read response data.
REQ-011 rf_Aaddr, rf_Baddr, rf_Caddr  out  4 each; rf_C  out  16; rf_load  out  1; rf_nClear  out  1 (synchronous clear, active-low) -- all drive the register file.
REQ-012 rf_A, rf_B  in  16 each  register file read data, one-cycle registered.
REQ-013 clr_req  in  1  level request for a register-file clear; busy  out  1  high whenever state is not RUN.

Function
REQ-014 The FSM SHALL have three states: INIT, RUN and CLR.
- Reset: enter INIT if INIT_CLEAR=1, else RUN.
- INIT -> RUN after exactly one cycle.
- RUN -> CLR on the next edge when clr_req=1.
- CLR -> RUN after exactly one cycle.
REQ-015 In INIT and CLR:
- rf_nClear=0, rf_load=0.
- Both readies SHALL be 0.
REQ-016 In RUN:
- rf_nClear=1.
- At most one requester SHALL be granted per cycle; a requester's ready SHALL be 1 only when it is granted.
REQ-017 Arbitration SHALL be round-robin:
- One valid: grant it.
- Both valid: grant the requester not granted most recently.
- The last-grant pointer SHALL update only on a grant; after reset it SHALL favour requester 0.
REQ-018 ready, rf_Aaddr, rf_Baddr, rf_Caddr, rf_C and rf_load SHALL be combinational from the granted request in the same cycle.
- rf_load = granted && we.
- With no grant, rf_load=0 and the address/data outputs SHALL be 0.
REQ-019 A granted read SHALL produce exactly one response cycle, the cycle immediately after the grant.
- rspN_valid=1 for the granted requester only.
- rspN_a=rf_A, rspN_b=rf_B.
- Latency: grant cycle plus one.
REQ-020 A registered pending flag plus requester tag SHALL track the outstanding response.
- rspN_a and rspN_b SHALL be 0 whenever rspN_valid=0.
- Back-to-back read grants SHALL produce back-to-back responses.
REQ-021 A granted write SHALL produce no response.
REQ-022 A write followed by a read of the same address in the next cycle SHALL return the new data. No forwarding logic is required; the register file provides this ordering.
REQ-023 clr_req=1 in a RUN cycle SHALL NOT block that cycle's grant; CLR follows on the next cycle.
- A read granted in that cycle SHALL still respond during the CLR cycle.
REQ-024 clr_req held high SHALL alternate CLR and RUN cycles.
REQ-025 Requests not granted SHALL remain pending at the requester. Requesters SHALL hold valid and command stable until ready.

Reset
REQ-026 On nClear=0, asynchronously:
- rsp0_valid and rsp1_valid SHALL go to 0, and the pending flag SHALL clear.
- The round-robin pointer SHALL favour requester 0.
- The state SHALL go to INIT (or RUN if INIT_CLEAR=0).
REQ-027 While nClear=0 and in INIT:
- rf_nClear=0, rf_load=0.
- Both readies SHALL be 0 and busy SHALL be 1.
REQ-028 A reset asserted mid-operation SHALL drop any outstanding read response; no response SHALL appear after reset release.

Verification
REQ-029 Reset release with INIT_CLEAR=1 -> exactly one cycle of rf_nClear=0 and busy=1, then RUN with busy=0.
REQ-030 req0 write caddr=5 data=16'hBEEF, next cycle req0 read aaddr=5 baddr=0 -> rsp0_valid one cycle after the read grant, rsp0_a=16'hBEEF, rsp0_b=0.
REQ-031 Both requesters continuously valid with reads for 6 cycles -> grants 0,1,0,1,0,1; responses alternate rsp0/rsp1, each one cycle after its grant.
REQ-032 clr_req pulsed high in the same cycle as a req1 read of r3=16'h1234 -> read granted, rsp1_a=16'h1234 during the CLR cycle, both readies 0 in CLR; a later read of r3 returns 0.
REQ-033 nClear pulsed low in the cycle after a read grant -> no rsp*_valid after reset; pointer favours req0 on the first contended cycle.
REQ-034 clr_req held high for 4 cycles in RUN -> rf_nClear pattern 1,0,1,0; grants occur only in RUN cycles.

Source files
------------

// File: rtl/reg_file_arb_if.sv
// ============================================================================
// Module      : reg_file_arb_if
// Description : Requester command/response and register-file bus bundle for
//               the two-port register-file arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_file_arb_if;
  logic        req0_valid, req0_ready, req0_we;
  logic [3:0]  req0_aaddr, req0_baddr, req0_caddr;
  logic [15:0] req0_data;
  logic        req1_valid, req1_ready, req1_we;
  logic [3:0]  req1_aaddr, req1_baddr, req1_caddr;
  logic [15:0] req1_data;

  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_a, rsp0_b, rsp1_a, rsp1_b;

  logic [3:0]  rf_Aaddr, rf_Baddr, rf_Caddr;
  logic [15:0] rf_C;
  logic        rf_load, rf_nClear;
  logic [15:0] rf_A, rf_B;

  logic        clr_req, busy;

  modport slave (
    input  req0_valid, req0_we, req0_aaddr, req0_baddr, req0_caddr, req0_data,
    input  req1_valid, req1_we, req1_aaddr, req1_baddr, req1_caddr, req1_data,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp0_a, rsp0_b, rsp1_a, rsp1_b,
    output rf_Aaddr, rf_Baddr, rf_Caddr, rf_C, rf_load, rf_nClear,
    input  rf_A, rf_B,
    input  clr_req,
    output busy
  );

  modport master (
    output req0_valid, req0_we, req0_aaddr, req0_baddr, req0_caddr, req0_data,
    output req1_valid, req1_we, req1_aaddr, req1_baddr, req1_caddr, req1_data,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp0_a, rsp0_b, rsp1_a, rsp1_b,
    input  rf_Aaddr, rf_Baddr, rf_Caddr, rf_C, rf_load, rf_nClear,
    output rf_A, rf_B,
    output clr_req,
    input  busy
  );
endinterface

`default_nettype wire

// File: rtl/reg_file_arb.sv
// ============================================================================
// Module      : reg_file_arb
// Description : Round-robin arbiter giving two requesters access to a
//               registered-read register file, with init/on-demand clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_arb #(
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic           clk,
  input  logic           nClear,
  reg_file_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_CLR  = 2'd2
  } state_t;

  localparam state_t RST_STATE = INIT_CLEAR ? ST_INIT : ST_RUN;

  state_t state_q;
  logic   busy_q, rf_nclear_q;
  logic   last_q, last_d;
  logic   pend_q, pend_d;
  logic   tag_q,  tag_d;
  logic   run, gnt0, gnt1;

  // last_q=1 means requester 1 won last, so requester 0 wins the next tie.
  assign run  = (state_q == ST_RUN);
  assign gnt0 = run && bus.req0_valid && (!bus.req1_valid ||  last_q);
  assign gnt1 = run && bus.req1_valid && (!bus.req0_valid || !last_q);

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  always_comb begin
    bus.rf_Aaddr = '0;
    bus.rf_Baddr = '0;
    bus.rf_Caddr = '0;
    bus.rf_C     = '0;
    bus.rf_load  = 1'b0;
    if (gnt0) begin
      bus.rf_Aaddr = bus.req0_aaddr;
      bus.rf_Baddr = bus.req0_baddr;
      bus.rf_Caddr = bus.req0_caddr;
      bus.rf_C     = bus.req0_data;
      bus.rf_load  = bus.req0_we;
    end else if (gnt1) begin
      bus.rf_Aaddr = bus.req1_aaddr;
      bus.rf_Baddr = bus.req1_baddr;
      bus.rf_Caddr = bus.req1_caddr;
      bus.rf_C     = bus.req1_data;
      bus.rf_load  = bus.req1_we;
    end
  end

  assign pend_d = (gnt0 && !bus.req0_we) || (gnt1 && !bus.req1_we);
  assign tag_d  = gnt1;
  assign last_d = (gnt0 || gnt1) ? gnt1 : last_q;

  always_ff @(posedge clk or negedge nClear) begin
    if (!nClear) begin
      state_q     <= RST_STATE;
      busy_q      <= INIT_CLEAR;
      rf_nclear_q <= ~INIT_CLEAR;
      last_q      <= 1'b1;
      pend_q      <= 1'b0;
      tag_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.clr_req) begin
            state_q     <= ST_CLR;
            busy_q      <= 1'b1;
            rf_nclear_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_RUN;
          busy_q      <= 1'b0;
          rf_nclear_q <= 1'b1;
        end
      endcase
      last_q <= last_d;
      pend_q <= pend_d;
      tag_q  <= tag_d;
    end
  end

  // Register file returns read data one cycle after the address, aligned with pend_q.
  assign bus.rsp0_valid = pend_q && !tag_q;
  assign bus.rsp1_valid = pend_q &&  tag_q;
  assign bus.rsp0_a     = bus.rsp0_valid ? bus.rf_A : '0;
  assign bus.rsp0_b     = bus.rsp0_valid ? bus.rf_B : '0;
  assign bus.rsp1_a     = bus.rsp1_valid ? bus.rf_A : '0;
  assign bus.rsp1_b     = bus.rsp1_valid ? bus.rf_B : '0;

  assign bus.busy      = busy_q;
  assign bus.rf_nClear = rf_nclear_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_arb.sv
// ============================================================================
// Module      : tb_reg_file_arb
// Description : Scoreboard bench for reg_file_arb with a behavioural register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_arb;

  logic clk = 1'b0;
  logic nClear;
  always #5 clk = ~clk;

  reg_file_arb_if bus ();

  reg_file_arb #(.INIT_CLEAR(1'b1)) dut (
    .clk    (clk),
    .nClear (nClear),
    .bus    (bus)
  );

  // Behavioural register file: synchronous clear/write, registered read.
  logic [15:0] rf_mem [16];
  always @(posedge clk) begin
    if (!bus.rf_nClear) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
    end else if (bus.rf_load) begin
      rf_mem[bus.rf_Caddr] <= bus.rf_C;
    end
    bus.rf_A <= rf_mem[bus.rf_Aaddr];
    bus.rf_B <= rf_mem[bus.rf_Baddr];
  end

  typedef struct {
    int          due;
    bit          port;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] shadow [16];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rc, input logic [15:0] d);
    if (p == 0) begin
      bus.req0_valid = v;  bus.req0_we = we;
      bus.req0_aaddr = ra; bus.req0_baddr = rb; bus.req0_caddr = rc;
      bus.req0_data  = d;
    end else begin
      bus.req1_valid = v;  bus.req1_we = we;
      bus.req1_aaddr = ra; bus.req1_baddr = rb; bus.req1_caddr = rc;
      bus.req1_data  = d;
    end
  endtask

  task automatic idle();
    set_req(0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0);
    set_req(1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0);
    bus.clr_req = 1'b0;
  endtask

  task automatic clear_shadow();
    for (int i = 0; i < 16; i++) shadow[i] = '0;
  endtask

  task automatic push_read(input int p, input logic [3:0] ra, input logic [3:0] rb);
    sb.push_back('{due: cyc + 1, port: p[0], a: shadow[ra], b: shadow[rb]});
  endtask

  // Response scoreboard
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [15:0] ga, gb;
    #2;
    if (bus.rsp0_valid || bus.rsp1_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got valid0=%b valid1=%b at cycle %0d, want no response",
                 bus.rsp0_valid, bus.rsp1_valid, cyc);
      end else begin
        e  = sb.pop_front();
        ga = bus.rsp1_valid ? bus.rsp1_a : bus.rsp0_a;
        gb = bus.rsp1_valid ? bus.rsp1_b : bus.rsp0_b;
        if ({bus.rsp0_valid, bus.rsp1_valid, ga, gb} !== {~e.port, e.port, e.a, e.b} || e.due != cyc) begin
          n_err++;
          $display("FAIL rsp_data: got v0=%b v1=%b a=%h b=%h cyc=%0d, want port=%0d a=%h b=%h cyc=%0d",
                   bus.rsp0_valid, bus.rsp1_valid, ga, gb, cyc, e.port, e.a, e.b, e.due);
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      n_cmp++;
      n_err++;
      $display("FAIL rsp_missing: got no response at cycle %0d, want port=%0d due cycle %0d",
               cyc, sb[0].port, sb[0].due);
      void'(sb.pop_front());
    end
    n_cmp++;
    if ((!bus.rsp0_valid && {bus.rsp0_a, bus.rsp0_b} !== 32'h0) ||
        (!bus.rsp1_valid && {bus.rsp1_a, bus.rsp1_b} !== 32'h0)) begin
      n_err++;
      $display("FAIL rsp_idle_data: got rsp0=%h/%h rsp1=%h/%h, want zero on idle port",
               bus.rsp0_a, bus.rsp0_b, bus.rsp1_a, bus.rsp1_b);
    end
  end

  task automatic test_reset();
    set_req(0, 1'b1, 1'b1, 4'd1, 4'd2, 4'd3, 16'h55AA);
    set_req(1, 1'b1, 1'b0, 4'd4, 4'd5, 4'd6, 16'h0);
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.busy, bus.rf_nClear, bus.req0_ready, bus.req1_ready, bus.rf_load,
         bus.rsp0_valid, bus.rsp1_valid} !== 7'b1000000) begin
      n_err++;
      $display("FAIL reset_hold: got %b want 1000000",
               {bus.busy, bus.rf_nClear, bus.req0_ready, bus.req1_ready, bus.rf_load,
                bus.rsp0_valid, bus.rsp1_valid});
    end
    idle();
    @(negedge clk);
    nClear = 1'b1;
    clear_shadow();
    #1;
    n_cmp++;
    if ({bus.busy, bus.rf_nClear, bus.req0_ready, bus.req1_ready} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_init: got %b want 1000",
               {bus.busy, bus.rf_nClear, bus.req0_ready, bus.req1_ready});
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.busy, bus.rf_nClear, bus.rf_load, bus.rf_Aaddr, bus.rf_Baddr, bus.rf_Caddr, bus.rf_C}
        !== {1'b0, 1'b1, 29'h0}) begin
      n_err++;
      $display("FAIL reset_run: got busy=%b nclr=%b load=%b addr=%h%h%h c=%h want 0 1 0 000 0000",
               bus.busy, bus.rf_nClear, bus.rf_load, bus.rf_Aaddr, bus.rf_Baddr, bus.rf_Caddr, bus.rf_C);
    end
  endtask

  task automatic test_round_robin();
    logic [9:0] want;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_req(0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 16'h0);
      set_req(1, 1'b1, 1'b0, 4'd3, 4'd4, 4'd0, 16'h0);
      #1;
      want = (i % 2 == 0) ? {2'b10, 4'd1, 4'd2} : {2'b01, 4'd3, 4'd4};
      n_cmp++;
      if ({bus.req0_ready, bus.req1_ready, bus.rf_Aaddr, bus.rf_Baddr} !== want) begin
        n_err++;
        $display("FAIL rr_grant%0d: got %b want %b", i,
                 {bus.req0_ready, bus.req1_ready, bus.rf_Aaddr, bus.rf_Baddr}, want);
      end
      if (i % 2 == 0) push_read(0, 4'd1, 4'd2);
      else            push_read(1, 4'd3, 4'd4);
    end
    @(negedge clk); idle();
    @(negedge clk);
  endtask

  task automatic test_write_read();
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd5, 16'hBEEF);
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, bus.rf_load, bus.rf_Caddr, bus.rf_C}
        !== {1'b1, 1'b0, 1'b1, 4'd5, 16'hBEEF}) begin
      n_err++;
      $display("FAIL wr_grant: got rdy=%b%b load=%b caddr=%h c=%h want 10 1 5 beef",
               bus.req0_ready, bus.req1_ready, bus.rf_load, bus.rf_Caddr, bus.rf_C);
    end
    shadow[5] = 16'hBEEF;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 4'd5, 4'd0, 4'd0, 16'h0);
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, bus.rf_load, bus.rf_Aaddr, bus.rf_Baddr}
        !== {1'b1, 1'b0, 1'b0, 4'd5, 4'd0}) begin
      n_err++;
      $display("FAIL rd_grant: got rdy=%b%b load=%b a=%h b=%h want 10 0 5 0",
               bus.req0_ready, bus.req1_ready, bus.rf_load, bus.rf_Aaddr, bus.rf_Baddr);
    end
    push_read(0, 4'd5, 4'd0);
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, bus.rf_load, bus.rf_Aaddr, bus.rf_Caddr, bus.rf_C} !== 27'h0) begin
      n_err++;
      $display("FAIL no_grant_zero: got rdy=%b%b load=%b a=%h c_addr=%h c=%h want all zero",
               bus.req0_ready, bus.req1_ready, bus.rf_load, bus.rf_Aaddr, bus.rf_Caddr, bus.rf_C);
    end
    @(negedge clk);
  endtask

  task automatic test_clear();
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd3, 16'h1234);
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, bus.rf_load} !== 3'b011) begin
      n_err++;
      $display("FAIL clr_write: got %b want 011", {bus.req0_ready, bus.req1_ready, bus.rf_load});
    end
    shadow[3] = 16'h1234;
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 4'd3, 4'd3, 4'd0, 16'h0);
    bus.clr_req = 1'b1;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, bus.rf_nClear, bus.busy} !== 4'b0110) begin
      n_err++;
      $display("FAIL clr_grant: got %b want 0110", {bus.req0_ready, bus.req1_ready, bus.rf_nClear, bus.busy});
    end
    push_read(1, 4'd3, 4'd3);
    @(negedge clk);
    bus.clr_req = 1'b0;
    set_req(1, 1'b1, 1'b0, 4'd3, 4'd5, 4'd0, 16'h0);
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, bus.rf_nClear, bus.busy} !== 4'b0001) begin
      n_err++;
      $display("FAIL clr_state: got %b want 0001", {bus.req0_ready, bus.req1_ready, bus.rf_nClear, bus.busy});
    end
    clear_shadow();
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, bus.rf_nClear, bus.busy} !== 4'b0110) begin
      n_err++;
      $display("FAIL clr_after: got %b want 0110", {bus.req0_ready, bus.req1_ready, bus.rf_nClear, bus.busy});
    end
    push_read(1, 4'd3, 4'd5);
    @(negedge clk); idle();
    @(negedge clk);
  endtask

  task automatic test_clr_hold();
    logic run;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.clr_req = 1'b1;
      set_req(0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 16'h0);
      #1;
      run = (i % 2 == 0);
      n_cmp++;
      if ({bus.rf_nClear, bus.busy, bus.req0_ready} !== {run, ~run, run}) begin
        n_err++;
        $display("FAIL clr_hold%0d: got %b want %b", i,
                 {bus.rf_nClear, bus.busy, bus.req0_ready}, {run, ~run, run});
      end
      if (run) push_read(0, 4'd1, 4'd2);
      else     clear_shadow();
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if ({bus.rf_nClear, bus.busy} !== 2'b10) begin
      n_err++;
      $display("FAIL clr_release: got %b want 10", {bus.rf_nClear, bus.busy});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 4'd5, 4'd3, 4'd0, 16'h0);
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL mid_grant: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    @(posedge clk); #1;
    nClear = 1'b0;
    idle();
    #1;
    n_cmp++;
    if ({bus.rsp0_valid, bus.rsp1_valid, bus.busy, bus.rf_nClear} !== 4'b0010) begin
      n_err++;
      $display("FAIL mid_reset: got %b want 0010",
               {bus.rsp0_valid, bus.rsp1_valid, bus.busy, bus.rf_nClear});
    end
    clear_shadow();
    @(negedge clk);
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 4'd5, 4'd3, 4'd0, 16'h0);
    set_req(1, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 16'h0);
    nClear = 1'b1;
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready, bus.busy} !== 3'b001) begin
      n_err++;
      $display("FAIL mid_init: got %b want 001", {bus.req0_ready, bus.req1_ready, bus.busy});
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL mid_ptr0: got %b want 10", {bus.req0_ready, bus.req1_ready});
    end
    push_read(0, 4'd5, 4'd3);
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL mid_ptr1: got %b want 01", {bus.req0_ready, bus.req1_ready});
    end
    push_read(1, 4'd1, 4'd2);
    @(negedge clk); idle();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_drain();
    @(negedge clk); #3;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d outstanding responses want 0", sb.size());
    end
  endtask

  initial begin
    nClear = 1'b0;
    idle();
    clear_shadow();
    repeat (3) @(posedge clk);
    test_reset();
    test_round_robin();
    test_write_read();
    test_clear();
    test_clr_hold();
    test_reset_mid();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at cycle %0d want completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
